// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared state encoding, widths and state decode helpers for prog_loader.
// The SUM state exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  typedef logic [DATA_W-1:0] byte_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_DATA  = 3'd1,
`ifdef LOADER_CHECKSUM_EN
    S_SUM   = 3'd2,
`endif
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;
  function automatic logic accepts(state_t s);
    return !(s inside {S_FLUSH, S_DONE, S_ERR});
  endfunction
endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream, start/status and memory write bus of the program loader.
interface prog_loader_if;
  import loader_pkg::*;
  logic  start;
  logic  in_valid;
  byte_t in_data;
  logic  in_ready;
  logic  mem_we;
  addr_t mem_addr;
  byte_t mem_data;
  logic  cpu_hold;
  logic  done;
  logic  error;
  modport master (
    output start, in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error
  );
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_data, cpu_hold, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed byte stream into memory at BASE_ADDR while holding the CPU.
// Define LOADER_CHECKSUM_EN to require a trailing modulo-256 payload checksum byte.
module prog_loader
  import loader_pkg::*;
#(
  parameter addr_t BASE_ADDR = 8'h00
) (
  input logic clk,
  input logic reset,
  prog_loader_if.slave bus
);
  state_t state, state_n;
  byte_t count, offset;
  logic xfer;
`ifdef LOADER_CHECKSUM_EN
  byte_t sum;
  localparam state_t TAIL = S_SUM;
`else
  localparam state_t TAIL = S_FLUSH;
`endif
  assign xfer = bus.in_valid && bus.in_ready;
  always_comb begin
    state_n = state;
    case (state)
      S_LEN:         if (xfer) state_n = bus.in_data == '0 ? TAIL : S_DATA;
      S_DATA:        if (xfer && count == 8'd1) state_n = TAIL;
`ifdef LOADER_CHECKSUM_EN
      S_SUM:         if (xfer) state_n = bus.in_data == sum ? S_FLUSH : S_ERR;
`endif
      S_FLUSH:       state_n = S_DONE;
      S_DONE, S_ERR: if (bus.start) state_n = S_LEN;
      default:       state_n = S_LEN;
    endcase
  end
  // status outputs are registered from the next state so they change with it
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_LEN;
      bus.in_ready <= 1'b1;
      bus.cpu_hold <= 1'b1;
      bus.done     <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= BASE_ADDR;
      bus.mem_data <= '0;
      count        <= '0;
      offset       <= '0;
    end else begin
      state        <= state_n;
      bus.in_ready <= accepts(state_n);
      bus.cpu_hold <= state_n != S_DONE;
      bus.done     <= state_n == S_DONE;
      bus.mem_we   <= xfer && state == S_DATA;
      if (xfer && state == S_LEN) begin
        count  <= bus.in_data;
        offset <= '0;
      end
      if (xfer && state == S_DATA) begin
        bus.mem_addr <= BASE_ADDR + offset;
        bus.mem_data <= bus.in_data;
        offset       <= offset + 8'd1;
        count        <= count - 8'd1;
      end
    end
  end
`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      sum       <= '0;
      bus.error <= 1'b0;
    end else begin
      bus.error <= state_n == S_ERR;
      if (xfer && state == S_LEN) sum <= '0;
      else if (xfer && state == S_DATA) sum <= sum + bus.in_data;
    end
  end
`else
  assign bus.error = 1'b0;
`endif
endmodule
